param_mem_mfc: RTL

PARAM_MEM_MFC -- requirements
Module: param_mem_mfc

---
 rtl/param_mem_mfc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/param_mem_mfc.sv
// Byte-addressed memory with an MFA/MFC handshake, configurable wait states and big-endian multi-byte access.
// Define PARAM_MEM_ALIGN_CHECK_EN to reject misaligned accesses instead of aligning them down.
module param_mem_mfc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic              SIGNED,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              MFC,
  output logic              ERR,
  output logic              BUSY
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

  logic [7:0]        mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        size_q,  size_d;
  logic              rw_q,    rw_d;
  logic              sgn_q,   sgn_d;
  logic [DATA_W-1:0] din_q,   din_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              mfc_q,   mfc_d;
  logic              err_q,   err_d;

  logic [3:0]        nBytes;
  logic [ADDR_W-1:0] sizeMask;
  logic [ADDR_W-1:0] baseAddr;
  logic              sizeBad;
  logic              reject;
  logic              signBit;
  logic [DATA_W-1:0] rdData;
  logic              memWe;

  // Access geometry comes only from the latched request, never from live inputs.
  always_comb begin
    nBytes   = 4'd1 << size_q;
    sizeMask = ADDR_W'(nBytes - 4'd1);
    sizeBad  = (DATA_W == 32) && (size_q == 2'b11);
`ifdef PARAM_MEM_ALIGN_CHECK_EN
    baseAddr = addr_q;
    reject   = sizeBad | (|(addr_q & sizeMask));
`else
    baseAddr = addr_q & ~sizeMask;
    reject   = sizeBad;
`endif
  end

  // Big-endian: the byte at baseAddr lands in the most significant used lane.
  always_comb begin
    rdData  = '0;
    signBit = sgn_q & mem_q[baseAddr][7];
    for (int j = 0; j < NB; j++) begin
      if (j < int'(nBytes)) begin
        rdData[8*j +: 8] = mem_q[baseAddr + ADDR_W'(int'(nBytes) - 1 - j)];
      end else begin
        rdData[8*j +: 8] = {8{signBit}};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    rw_d    = rw_q;
    sgn_d   = sgn_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    err_d   = err_q;
    memWe   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MFA) begin
          addr_d  = ADDR;
          size_d  = SIZE;
          rw_d    = RW;
          sgn_d   = SIGNED;
          din_d   = DataIn;
          cnt_d   = WAIT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!MFA) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mfc_d   = 1'b1;
          err_d   = reject;
          state_d = ST_DONE;
          if (!reject) begin
            if (rw_q) begin
              memWe = 1'b1;
            end else begin
              dout_d = rdData;
            end
          end
        end
      end
      ST_DONE: begin
        if (!MFA) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      sgn_q   <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      sgn_q   <= sgn_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  // No reset here: contents survive CLR, and reset forces IDLE so a pending write never fires.
  always_ff @(posedge CLK) begin
    if (memWe) begin
      for (int j = 0; j < NB; j++) begin
        if (j < int'(nBytes)) begin
          mem_q[baseAddr + ADDR_W'(int'(nBytes) - 1 - j)] <= din_q[8*j +: 8];
        end
      end
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q == ST_BUSY) || (state_q == ST_DONE);

endmodule
